// File: rtl/axi_burst_write_master_pkg.sv
// Shared types, AXI constants and KSEG address mapping for the AXI burst masters.
package axi_burst_write_master_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LEN_W  = 4;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } wr_state_e;

    // Latched write-address payload for the burst in flight.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } aw_req_t;

    // kseg0/kseg1 (0x8000_0000..0xBFFF_FFFF) alias physical memory from 0.
    function automatic logic [ADDR_W-1:0] kseg_to_phys(input logic [ADDR_W-1:0] vaddr,
                                                       input bit enable);
        if (enable && ((vaddr[31:29] == 3'b100) || (vaddr[31:29] == 3'b101))) begin
            return {3'b000, vaddr[28:0]};
        end
        return vaddr;
    endfunction

endpackage

// File: rtl/axi_burst_write_master_kseg_map.sv
// Combinational virtual-to-physical translation shared by the read and write masters.
module axi_kseg_map
    import axi_burst_write_master_pkg::*;
#(
    parameter bit ENABLE = 1'b1
) (
    input  logic [ADDR_W-1:0] vaddr,
    output logic [ADDR_W-1:0] paddr
);

    // Pure translation, no state.
    always_comb begin
        paddr = kseg_to_phys(vaddr, ENABLE);
    end

endmodule

// File: rtl/axi_burst_write_master.sv
// AXI3 write master: one INCR burst per request, independent AW/W, one outstanding.
module axi_burst_write_master
    import axi_burst_write_master_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned AXI_ID   = 0,
    parameter int unsigned MAX_LEN  = 16,
    parameter bit          KSEG_MAP = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_addr,
    input  logic [3:0]          req_len,
    input  logic                dat_valid,
    output logic                dat_ready,
    input  logic [DATA_W-1:0]   dat_data,
    input  logic [DATA_W/8-1:0] dat_strb,
    output logic                done,
    output logic                err,
    output logic [ID_W-1:0]     awid,
    output logic [31:0]         awaddr,
    output logic [3:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [1:0]          awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,
    output logic [ID_W-1:0]     wid,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [ID_W-1:0]     bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    localparam int unsigned     STRB_W  = DATA_W / 8;
    localparam logic [2:0]      AW_SIZE = 3'($clog2(STRB_W));
    localparam logic [LEN_W-1:0] LEN_CAP = LEN_W'(MAX_LEN - 1);

    wr_state_e          state_q, state_d;
    aw_req_t            aw_q, aw_d;
    logic               awvalid_q, awvalid_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic               req_ready_q, req_ready_d;
    logic               bready_q, bready_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [ADDR_W-1:0]  req_paddr;
    logic               w_hs;
    logic               unused_bid;

    // Response ID is not checked: only one transaction is ever outstanding.
    assign unused_bid = ^bid;

    axi_kseg_map #(
        .ENABLE (KSEG_MAP)
    ) u_kseg_map (
        .vaddr (req_addr),
        .paddr (req_paddr)
    );

    // Fixed AXI attributes.
    assign awid    = ID_W'(AXI_ID);
    assign wid     = ID_W'(AXI_ID);
    assign awsize  = AW_SIZE;
    assign awburst = BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;

    // W channel is a gated pass-through of the beat source.
    assign wvalid    = (state_q == ST_XFER) && dat_valid && !w_done_q;
    assign wdata     = dat_data;
    assign wstrb     = dat_strb;
    assign wlast     = (beat_q == aw_q.len);
    assign dat_ready = wready && wvalid;
    assign w_hs      = wvalid && wready;

    assign awaddr    = aw_q.addr;
    assign awlen     = aw_q.len;
    assign awvalid   = awvalid_q;
    assign req_ready = req_ready_q;
    assign bready    = bready_q;
    assign done      = done_q;
    assign err       = err_q;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            aw_q        <= '0;
            awvalid_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            beat_q      <= '0;
            req_ready_q <= 1'b0;
            bready_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            aw_q        <= aw_d;
            awvalid_q   <= awvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            beat_q      <= beat_d;
            req_ready_q <= req_ready_d;
            bready_q    <= bready_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        aw_d      = aw_q;
        awvalid_d = awvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        beat_d    = beat_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                awvalid_d = 1'b0;
                if (req_valid && req_ready_q) begin
                    aw_d.addr = req_paddr;
                    aw_d.len  = (req_len > LEN_CAP) ? LEN_CAP : req_len;
                    beat_d    = '0;
                    awvalid_d = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_XFER;
                end
            end
            ST_XFER: begin
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    beat_d = LEN_W'(beat_q + 1'b1);
                    if (wlast) begin
                        w_done_d = 1'b1;
                    end
                end
                if (aw_done_d && w_done_d) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bvalid && bready_q) begin
                    done_d  = 1'b1;
                    err_d   = |(bresp & RESP_SLVERR);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                awvalid_d = 1'b0;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
        bready_d    = (state_d == ST_RESP);
    end

endmodule

// File: tb/tb_axi_burst_write_master.sv
// Scoreboard bench for axi_burst_write_master: per-cycle driven AW/W/B slave model.
module tb_axi_burst_write_master;

    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned IDW = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } beat_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid;
    logic           req_ready;
    logic [31:0]    req_addr;
    logic [3:0]     req_len;
    logic           dat_valid;
    logic           dat_ready;
    logic [DW-1:0]  dat_data;
    logic [SW-1:0]  dat_strb;
    logic           done;
    logic           err;
    logic [IDW-1:0] awid;
    logic [31:0]    awaddr;
    logic [3:0]     awlen;
    logic [2:0]     awsize;
    logic [1:0]     awburst;
    logic [1:0]     awlock;
    logic [3:0]     awcache;
    logic [2:0]     awprot;
    logic           awvalid;
    logic           awready;
    logic [IDW-1:0] wid;
    logic [DW-1:0]  wdata;
    logic [SW-1:0]  wstrb;
    logic           wlast;
    logic           wvalid;
    logic           wready;
    logic [IDW-1:0] bid;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready;
    logic [31:0]    k_in;
    logic [31:0]    k_out;

    int n_vec = 0;
    int n_err = 0;
    beat_t exp_w_q[$];
    logic  exp_b_q[$];

    always #5 clk = ~clk;

    axi_burst_write_master #(
        .DATA_W(DW), .ID_W(IDW), .AXI_ID(0), .MAX_LEN(16), .KSEG_MAP(1'b1)
    ) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data), .dat_strb(dat_strb),
        .done(done), .err(err),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    axi_kseg_map #(.ENABLE(1'b0)) u_kseg_off (.vaddr(k_in), .paddr(k_out));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request driven through a cycle-accurate slave model; abort_at >= 0 resets mid-burst.
    task automatic do_txn(input logic [31:0] addr, input logic [31:0] exp_addr,
                          input logic [3:0] len, input logic [1:0] resp,
                          input int aw_delay, input bit wtoggle, input int gap_at,
                          input bit early_b, input int abort_at, input int exp_done_cyc);
        logic [DW-1:0] data [16];
        logic [SW-1:0] strb [16];
        int  beats = 0;
        int  wait_n = 0;
        int  gap_left = 0;
        bit  gap_used = 1'b0;
        bit  aw_seen = 1'b0;
        bit  b_pend = 1'b0;
        bit  b_taken = 1'b0;
        bit  got_done = 1'b0;
        beat_t e;
        logic  e_err;

        for (int i = 0; i <= int'(len); i++) begin
            data[i] = $urandom;
            strb[i] = SW'($urandom_range(1, (1 << SW) - 1));
            exp_w_q.push_back('{data: data[i], strb: strb[i], last: (i == int'(len))});
        end
        exp_b_q.push_back(resp[1]);

        req_valid = 1'b1; req_addr = addr; req_len = len;
        dat_valid = 1'b1; dat_data = data[0]; dat_strb = strb[0];
        awready = 1'b0; wready = 1'b1; bvalid = 1'b0;
        #1;
        while (!req_ready && wait_n < 20) begin
            tick(); #1; wait_n++;
        end
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL req_accept: req_ready=%b required 1", req_ready);
            req_valid = 1'b0; exp_w_q.delete(); exp_b_q.delete();
            return;
        end
        n_vec++;
        if (awvalid !== 1'b0 || wvalid !== 1'b0) begin
            n_err++; $display("FAIL idle_valids: awvalid=%b wvalid=%b required 0 0", awvalid, wvalid);
        end
        tick();
        req_valid = 1'b0;

        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (abort_at >= 0 && beats == abort_at) begin
                reset = 1'b1; awready = 1'b0; wready = 1'b0; dat_valid = 1'b1; bvalid = 1'b0;
                tick();
                reset = 1'b0;
                #1;
                n_vec++;
                if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0 || done !== 1'b0) begin
                    n_err++;
                    $display("FAIL abort_state: awvalid=%b wvalid=%b bready=%b done=%b required 0 0 0 0",
                             awvalid, wvalid, bready, done);
                end
                dat_valid = 1'b0;
                tick(); #1;
                n_vec++;
                if (done !== 1'b0 || req_ready !== 1'b1) begin
                    n_err++; $display("FAIL abort_idle: done=%b req_ready=%b required 0 1", done, req_ready);
                end
                exp_w_q.delete(); exp_b_q.delete();
                return;
            end

            if (!gap_used && gap_at >= 0 && beats == gap_at) begin
                gap_left = 2; gap_used = 1'b1;
            end
            dat_valid = (beats <= int'(len)) && (gap_left == 0);
            dat_data  = (beats <= int'(len)) ? data[beats] : '0;
            dat_strb  = (beats <= int'(len)) ? strb[beats] : '0;
            awready   = (cyc > aw_delay);
            wready    = wtoggle ? (cyc % 2 == 1) : 1'b1;
            bvalid    = b_pend || early_b;
            bresp     = resp;
            #1;

            if (awvalid) begin
                n_vec++;
                if (aw_seen || awaddr !== exp_addr || awlen !== len) begin
                    n_err++;
                    $display("FAIL aw_hold cyc%0d: seen=%b awaddr=%h awlen=%0d required %h %0d",
                             cyc, aw_seen, awaddr, awlen, exp_addr, len);
                end
                if (awready) aw_seen = 1'b1;
            end
            n_vec++;
            if (wvalid && !dat_valid) begin
                n_err++; $display("FAIL wvalid_gate cyc%0d: wvalid=1 with dat_valid=0 required 0", cyc);
            end
            if (wvalid && wready) begin
                n_vec++;
                if (exp_w_q.size() == 0) begin
                    n_err++; $display("FAIL w_extra cyc%0d: unexpected beat data=%h", cyc, wdata);
                end else begin
                    e = exp_w_q.pop_front();
                    if (wdata !== e.data || wstrb !== e.strb || wlast !== e.last || dat_ready !== 1'b1) begin
                        n_err++;
                        $display("FAIL w_beat%0d: data=%h strb=%h last=%b rdy=%b required %h %h %b 1",
                                 beats, wdata, wstrb, wlast, dat_ready, e.data, e.strb, e.last);
                    end
                end
                beats++;
            end
            if (bvalid && bready) begin
                n_vec++;
                if (!(aw_seen && beats == int'(len) + 1) || b_taken) begin
                    n_err++; $display("FAIL b_early cyc%0d: bready=1 before burst complete", cyc);
                end
                b_taken = 1'b1;
            end
            if (done) begin
                n_vec++;
                e_err = (exp_b_q.size() != 0) ? exp_b_q.pop_front() : 1'bx;
                if (err !== e_err || (exp_done_cyc > 0 && cyc != exp_done_cyc)) begin
                    n_err++;
                    $display("FAIL done_pulse: cyc=%0d err=%b required cyc=%0d err=%b",
                             cyc, err, exp_done_cyc, e_err);
                end
                got_done = 1'b1;
                break;
            end
            if (gap_left > 0) gap_left--;
            if (aw_seen && beats == int'(len) + 1 && !b_taken) b_pend = 1'b1;
            if (b_taken) b_pend = 1'b0;
            tick();
        end

        n_vec++;
        if (!got_done || beats != int'(len) + 1 || exp_w_q.size() != 0) begin
            n_err++;
            $display("FAIL txn_end: done=%b beats=%0d left=%0d required 1 %0d 0",
                     got_done, beats, exp_w_q.size(), int'(len) + 1);
        end
        exp_w_q.delete(); exp_b_q.delete();
        dat_valid = 1'b0; bvalid = 1'b0; awready = 1'b0;
        tick(); #1;
        n_vec++;
        if (done !== 1'b0 || req_ready !== 1'b1) begin
            n_err++; $display("FAIL after_done: done=%b req_ready=%b required 0 1", done, req_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_vec++;
        if ({awvalid, wvalid, bready, done, err, req_ready} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outs: av=%b wv=%b br=%b dn=%b er=%b rr=%b required all 0",
                     awvalid, wvalid, bready, done, err, req_ready);
        end
        n_vec++;
        if (awburst !== 2'b01 || awsize !== 3'd2 || awid !== 4'd0 || wid !== 4'd0) begin
            n_err++;
            $display("FAIL consts: burst=%b size=%0d awid=%0d wid=%0d required 01 2 0 0",
                     awburst, awsize, awid, wid);
        end
        n_vec++;
        if ({awlock, awcache, awprot} !== 9'b0) begin
            n_err++; $display("FAIL attr: lock/cache/prot=%b required 0", {awlock, awcache, awprot});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        do_txn(32'h8000_1000, 32'h0000_1000, 4'd0, 2'b00, 0, 1'b0, -1, 1'b0, -1, 3);
    endtask

    task automatic test_w_before_aw();
        do_txn(32'h0000_4000, 32'h0000_4000, 4'd3, 2'b00, 5, 1'b0, -1, 1'b0, -1, 8);
    endtask

    task automatic test_backpressure();
        do_txn(32'h0001_0000, 32'h0001_0000, 4'd15, 2'b00, 2, 1'b1, 5, 1'b1, -1, 0);
    endtask

    task automatic test_error_then_next();
        do_txn(32'h0000_3000, 32'h0000_3000, 4'd1, 2'b10, 0, 1'b0, -1, 1'b0, -1, 4);
        do_txn(32'h0000_3100, 32'h0000_3100, 4'd0, 2'b00, 0, 1'b0, -1, 1'b0, -1, 3);
    endtask

    task automatic test_reset_mid();
        do_txn(32'h0000_5000, 32'h0000_5000, 4'd7, 2'b00, 0, 1'b0, -1, 1'b0, 2, 0);
        do_txn(32'h0000_6000, 32'h0000_6000, 4'd2, 2'b00, 0, 1'b0, -1, 1'b0, -1, 5);
    endtask

    task automatic test_kseg();
        do_txn(32'hBFC0_0000, 32'h1FC0_0000, 4'd1, 2'b00, 1, 1'b0, -1, 1'b0, -1, 0);
        do_txn(32'h0000_2000, 32'h0000_2000, 4'd0, 2'b00, 0, 1'b0, -1, 1'b0, -1, 3);
        do_txn(32'hA000_0040, 32'h0000_0040, 4'd0, 2'b00, 0, 1'b0, -1, 1'b0, -1, 3);
        do_txn(32'hC000_0080, 32'hC000_0080, 4'd0, 2'b00, 0, 1'b0, -1, 1'b0, -1, 3);
        k_in = 32'hBFC0_0000;
        #1;
        n_vec++;
        if (k_out !== 32'hBFC0_0000) begin
            n_err++; $display("FAIL kseg_off: paddr=%h required bfc00000", k_out);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
        dat_valid = 1'b0; dat_data = '0; dat_strb = '0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = 2'b00; bvalid = 1'b0;
        k_in = '0;
        test_reset();
        test_single();
        test_w_before_aw();
        test_backpressure();
        test_error_then_next();
        test_reset_mid();
        test_kseg();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
